// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ddram_arb_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        GAP
    } arb_state_t;

endpackage

// File: rtl/ddram_arb.sv
// Two-port arbiter in front of a single memory stage with a busy handshake.
// Latency: request sampled in IDLE -> ack 4 cycles later at best; one access per 5 cycles.
// Backpressure: ports hold req until their ack; mem_busy stalls STROBE/WAIT and blocks new grants.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   a_* / b_*           : requester ports (req level, we, be, word addr, din in; dout, ack out)
//   mem_addr, mem_din   : registered address/data towards memory, held for the whole access
//   mem_rd, mem_wr      : registered read strobe / write byte strobes, forced low in GAP
//   mem_dout, mem_busy  : read data and busy from the memory stage
module ddram_arb
    import ddram_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [BE_W-1:0]   a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [BE_W-1:0]   b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic [BE_W-1:0]   mem_wr,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy
);

    arb_state_t        state_q, state_d;
    logic              sel_b_q, sel_b_d;    // port owning the in-flight access
    logic              last_b_q, last_b_d;  // port granted most recently
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rd_q, rd_d;
    logic [BE_W-1:0]   wr_q, wr_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_dout_q, a_dout_d;
    logic [DATA_W-1:0] b_dout_q, b_dout_d;

    // Port-select mux for the grant decision made in IDLE.
    logic              pick_b;
    logic              g_we;
    logic [BE_W-1:0]   g_be;

    assign pick_b = (a_req && b_req) ? ((FAIR != 0) && !last_b_q) : b_req;
    assign g_we   = pick_b ? b_we : a_we;
    assign g_be   = pick_b ? b_be : a_be;

    always_comb begin
        state_d  = state_q;
        sel_b_d  = sel_b_q;
        last_b_d = last_b_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        a_dout_d = a_dout_q;
        b_dout_d = b_dout_q;

        unique case (state_q)
            IDLE: begin
                // mem_busy also covers an access orphaned by a reset.
                if (!mem_busy && (a_req || b_req)) begin
                    sel_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = g_we;
                    addr_d   = pick_b ? b_addr : a_addr;
                    din_d    = pick_b ? b_din : a_din;
                    if (g_we && (g_be == '0)) begin
                        // Nothing to write: finish without touching memory.
                        state_d = GAP;
                        a_ack_d = !pick_b;
                        b_ack_d = pick_b;
                    end else begin
                        state_d = STROBE;
                        rd_d    = !g_we;
                        wr_d    = g_we ? g_be : '0;
                    end
                end
            end
            STROBE: begin
                if (mem_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    state_d = GAP;
                    rd_d    = 1'b0;
                    wr_d    = '0;
                    a_ack_d = !sel_b_q;
                    b_ack_d = sel_b_q;
                    if (!we_q) begin
                        if (sel_b_q) begin
                            b_dout_d = mem_dout;
                        end else begin
                            a_dout_d = mem_dout;
                        end
                    end
                end
            end
            GAP: begin
                // Strobes are low here, so the next access always shows a rising edge.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_b_q  <= 1'b0;
            last_b_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_b_q  <= sel_b_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_rd   = rd_q;
    assign mem_wr   = wr_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_dout   = a_dout_q;
    assign b_dout   = b_dout_q;

endmodule

// File: tb/tb_ddram_arb.sv
// Directed bench for ddram_arb: index 0 is the round-robin build, index 1 fixed priority.
// Both builds see the same port stimulus; each has its own memory busy model.
// Memory model: busy rises the cycle after a strobe rising edge and stays high busy_len cycles.
module tb_ddram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be;
    logic [25:0] a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [31:0] rd_data;

    logic [31:0] a_dout [2];
    logic [31:0] b_dout [2];
    logic        a_ack [2];
    logic        b_ack [2];
    logic [25:0] mem_addr [2];
    logic [31:0] mem_din [2];
    logic        mem_rd [2];
    logic [3:0]  mem_wr [2];
    logic        mem_busy [2] = '{1'b0, 1'b0};

    int          busy_len = 1;
    int          remain [2] = '{0, 0};
    logic        strb_prev [2] = '{1'b0, 1'b0};

    int          a_cnt [2] = '{0, 0};
    int          b_cnt [2] = '{0, 0};
    int          both_cnt = 0;

    int          n_pass = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ddram_arb #(.FAIR(g == 0 ? 1 : 0)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .a_req    (a_req),
            .a_we     (a_we),
            .a_be     (a_be),
            .a_addr   (a_addr),
            .a_din    (a_din),
            .a_dout   (a_dout[g]),
            .a_ack    (a_ack[g]),
            .b_req    (b_req),
            .b_we     (b_we),
            .b_be     (b_be),
            .b_addr   (b_addr),
            .b_din    (b_din),
            .b_dout   (b_dout[g]),
            .b_ack    (b_ack[g]),
            .mem_addr (mem_addr[g]),
            .mem_din  (mem_din[g]),
            .mem_rd   (mem_rd[g]),
            .mem_wr   (mem_wr[g]),
            .mem_dout (rd_data),
            .mem_busy (mem_busy[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            strb_prev[g] <= mem_rd[g] | (|mem_wr[g]);
            if (remain[g] > 1) begin
                remain[g] <= remain[g] - 1;
            end else if (remain[g] == 1) begin
                remain[g]   <= 0;
                mem_busy[g] <= 1'b0;
            end else if ((mem_rd[g] | (|mem_wr[g])) && !strb_prev[g]) begin
                remain[g]   <= busy_len;
                mem_busy[g] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (a_ack[g]) a_cnt[g] <= a_cnt[g] + 1;
            if (b_ack[g]) b_cnt[g] <= b_cnt[g] + 1;
        end
        if ((a_ack[0] && b_ack[0]) || (a_ack[1] && b_ack[1])) both_cnt <= both_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        int          c, t1, t2, nr, n0, n1, fall_c, a0, b0, b1;
        logic        ok, prev;
        logic [3:0]  seq0, seq1;

        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_din = '0;
        b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_din = '0;
        rd_data = 32'h0;
        repeat (3) tick();

        // Reset state
        chk("rst_mem_rd",   32'(mem_rd[0]),   32'd0);
        chk("rst_mem_wr",   32'(mem_wr[0]),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
        chk("rst_mem_din",  mem_din[0],       32'd0);
        chk("rst_a_ack",    32'(a_ack[0]),    32'd0);
        chk("rst_b_ack",    32'(b_ack[0]),    32'd0);
        chk("rst_a_dout",   a_dout[0],        32'd0);
        chk("rst_b_dout",   b_dout[0],        32'd0);
        reset = 1'b0;
        tick();

        // Both ports requesting continuously: RR gives B,A,B,A; fixed gives A,A,A,A
        a_addr = 26'h10; b_addr = 26'h20; a_req = 1'b1; b_req = 1'b1;
        seq0 = 4'h0; seq1 = 4'h0; n0 = 0; n1 = 0; c = 0;
        while (n0 < 4 && c < 60) begin
            tick(); c++;
            if (a_ack[0] || b_ack[0]) begin seq0 = {seq0[2:0], b_ack[0]}; n0++; end
            if (a_ack[1] || b_ack[1]) begin seq1 = {seq1[2:0], b_ack[1]}; n1++; end
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("rr_grants",   32'(n0),   32'd4);
        chk("rr_order",    32'(seq0), 32'hA);
        chk("fixed_grants", 32'(n1),  32'd4);
        chk("fixed_order", 32'(seq1), 32'h0);
        repeat (3) tick();

        // Single A read, busy 1 cycle: ack at cycle 4
        rd_data = 32'hDEADBEEF; a_addr = 26'h0000100; a_we = 1'b0; a_req = 1'b1;
        b0 = b_cnt[0];
        tick();
        chk("rd_c1_strobe", 32'(mem_rd[0]),   32'd1);
        chk("rd_c1_addr",   32'(mem_addr[0]), 32'h100);
        chk("rd_c1_wr",     32'(mem_wr[0]),   32'd0);
        a_addr = 26'h3FF;
        tick();
        chk("rd_c2_busy",   32'(mem_busy[0]), 32'd1);
        chk("rd_c2_addr",   32'(mem_addr[0]), 32'h100);
        tick();
        chk("rd_c3_ack",    32'(a_ack[0]),    32'd0);
        tick();
        chk("rd_c4_ack",    32'(a_ack[0]),    32'd1);
        chk("rd_c4_dout",   a_dout[0],        32'hDEADBEEF);
        chk("rd_c4_strobe", 32'(mem_rd[0]),   32'd0);
        a_req = 1'b0;
        tick();
        chk("rd_ack_pulse", 32'(a_ack[0]),    32'd0);
        repeat (3) tick();
        chk("rd_no_b_ack",  32'(b_cnt[0] - b0), 32'd0);

        // Write with no byte enables: ack the cycle after grant, no strobe
        a_addr = 26'h55; a_we = 1'b1; a_be = 4'h0; a_din = 32'hFFFF0000; a_req = 1'b1;
        tick();
        chk("be0_ack",     32'(a_ack[0]),    32'd1);
        chk("be0_rd",      32'(mem_rd[0]),   32'd0);
        chk("be0_wr",      32'(mem_wr[0]),   32'd0);
        chk("be0_dout",    a_dout[0],        32'hDEADBEEF);
        a_req = 1'b0; a_we = 1'b0;
        tick();
        chk("be0_no_busy", 32'(mem_busy[0]), 32'd0);

        // B write, busy 3 cycles
        busy_len = 3;
        b_addr = 26'h0000204; b_we = 1'b1; b_be = 4'b0011; b_din = 32'h12345678; b_req = 1'b1;
        b0 = b_cnt[0];
        tick(); c = 1;
        chk("wr_c1_addr", 32'(mem_addr[0]), 32'h204);
        chk("wr_c1_rd",   32'(mem_rd[0]),   32'd0);
        b_din = 32'h0;
        ok = 1'b1;
        while (!b_ack[0] && c < 20) begin
            ok = ok && (mem_wr[0] == 4'b0011) && (mem_din[0] == 32'h12345678);
            tick(); c++;
        end
        chk("wr_stable",   32'(ok),        32'd1);
        chk("wr_ack_cyc",  32'(c),         32'd6);
        chk("wr_ack_wr0",  32'(mem_wr[0]), 32'd0);
        chk("wr_b_dout",   b_dout[0],      32'd0);
        b_req = 1'b0; b_we = 1'b0; b_be = 4'h0;
        repeat (3) tick();
        chk("wr_b_once",   32'(b_cnt[0] - b0), 32'd1);

        // Back-to-back A reads
        busy_len = 1; rd_data = 32'hCAFE0001; a_addr = 26'h40; a_req = 1'b1;
        prev = mem_rd[0]; c = 0; t1 = -1; t2 = -1; nr = 0; n0 = 0;
        while (n0 < 2 && c < 40) begin
            tick(); c++;
            if (mem_rd[0] && !prev) begin
                nr++;
                if (t1 < 0) t1 = c; else t2 = c;
            end
            prev = mem_rd[0];
            if (a_ack[0]) n0++;
        end
        a_req = 1'b0;
        chk("b2b_acks",  32'(n0), 32'd2);
        chk("b2b_rises", 32'(nr), 32'd2);
        chk("b2b_gap",   32'((t2 - t1) >= 5), 32'd1);
        chk("b2b_dout",  a_dout[0], 32'hCAFE0001);
        repeat (3) tick();

        // Reset in WAIT with busy held 10 cycles, B pending
        busy_len = 10; a_addr = 26'h77; a_req = 1'b1;
        a0 = a_cnt[0]; b0 = b_cnt[0]; b1 = b_cnt[1];
        tick(); tick(); tick();
        chk("rst_wait_rd",   32'(mem_rd[0]),   32'd1);
        chk("rst_wait_busy", 32'(mem_busy[0]), 32'd1);
        reset = 1'b1; a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 26'h99; rd_data = 32'h0BADF00D;
        tick(); c = 4;
        chk("rst_drop_rd", 32'(mem_rd[0]), 32'd0);
        chk("rst_a_dout0", a_dout[0],      32'd0);
        reset = 1'b0; busy_len = 1;
        ok = 1'b1;
        while (!mem_rd[0] && c < 40) begin
            ok = ok && !a_ack[0] && !b_ack[0] && (mem_wr[0] == 4'h0);
            tick(); c++;
        end
        chk("rst_quiet",      32'(ok),          32'd1);
        chk("rst_strobe_cyc", 32'(c),           32'd13);
        chk("rst_b_addr",     32'(mem_addr[0]), 32'h99);
        while (!b_ack[0] && c < 60) begin
            tick(); c++;
        end
        chk("rst_b_ack_cyc",  32'(c),     32'd16);
        chk("rst_b_dout",     b_dout[0],  32'h0BADF00D);
        b_req = 1'b0;
        repeat (3) tick();
        chk("rst_no_a_ack",   32'(a_cnt[0] - a0), 32'd0);
        chk("rst_b_once",     32'(b_cnt[0] - b0), 32'd1);
        chk("rst_fixed_b",    32'(b_cnt[1] - b1), 32'd1);

        // Long miss: busy 20 cycles
        busy_len = 20; rd_data = 32'h5A5A5A5A; a_addr = 26'h2AAAAAA; a_req = 1'b1;
        c = 0; fall_c = -1; ok = 1'b1; prev = 1'b0;
        while (!a_ack[0] && c < 60) begin
            tick(); c++;
            if (!a_ack[0]) ok = ok && mem_rd[0] && (mem_addr[0] == 26'h2AAAAAA);
            if (prev && !mem_busy[0] && fall_c < 0) fall_c = c;
            prev = mem_busy[0];
        end
        a_req = 1'b0;
        chk("miss_stable",   32'(ok),         32'd1);
        chk("miss_ack_cyc",  32'(c),          32'd23);
        chk("miss_ack_fall", 32'(c - fall_c), 32'd1);
        chk("miss_dout",     a_dout[0],       32'h5A5A5A5A);
        chk("miss_ack_rd",   32'(mem_rd[0]),  32'd0);
        repeat (3) tick();

        chk("no_dual_ack", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
